// File: rtl/execute_stage_if.sv
// execute_stage_if: decode-to-execute inputs, forwarding controls and EX/MEM outputs of the execute stage
interface execute_stage_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  RegWriteE;
    logic                  ALUSrcE;
    logic                  MemWriteE;
    logic                  ResultSrcE;
    logic                  BranchE;
    logic [2:0]            ALUControlE;
    logic [XLEN-1:0]       RD1E;
    logic [XLEN-1:0]       RD2E;
    logic [XLEN-1:0]       ImmExtE;
    logic [XLEN-1:0]       PCE;
    logic [XLEN-1:0]       PCPlus4E;
    logic [REG_ADDR_W-1:0] RDE;
    logic [1:0]            ForwardAE;
    logic [1:0]            ForwardBE;
    logic [XLEN-1:0]       ResultW;
    logic                  FlushE;
    logic                  PCSrcE;
    logic [XLEN-1:0]       PCTargetE;
    logic                  RegWriteM;
    logic                  MemWriteM;
    logic                  ResultSrcM;
    logic [REG_ADDR_W-1:0] RDM;
    logic [XLEN-1:0]       ALUResultM;
    logic [XLEN-1:0]       WriteDataM;
    logic [XLEN-1:0]       PCPlus4M;

    modport master (
        output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
               RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RDE, ForwardAE, ForwardBE,
               ResultW, FlushE,
        input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RDM,
               ALUResultM, WriteDataM, PCPlus4M
    );

    modport slave (
        input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
               RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RDE, ForwardAE, ForwardBE,
               ResultW, FlushE,
        output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RDM,
               ALUResultM, WriteDataM, PCPlus4M
    );
endinterface

// File: rtl/execute_stage.sv
// execute_stage: operand forwarding, ALU, beq resolution, branch target and EX/MEM register
module execute_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input logic          clk,
    input logic          rst,
    execute_stage_if.slave bus
);
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            lt;

    // Forwarding muxes; ALUResultM is our own registered output, i.e. the previous instruction's result
    always_comb begin
        src_a = bus.ForwardAE == 2'b01 ? bus.ResultW :
                bus.ForwardAE == 2'b10 ? bus.ALUResultM : bus.RD1E;
        fwd_b = bus.ForwardBE == 2'b01 ? bus.ResultW :
                bus.ForwardBE == 2'b10 ? bus.ALUResultM : bus.RD2E;
        src_b = bus.ALUSrcE ? bus.ImmExtE : fwd_b;
    end

    // ALU; unused operation codes produce zero
    always_comb begin
        lt = $signed(src_a) < $signed(src_b);
        case (bus.ALUControlE)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = src_a - src_b;
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b101:  alu_result = {{(XLEN-1){1'b0}}, lt};
            default: alu_result = '0;
        endcase
    end

    assign bus.PCSrcE    = bus.BranchE & (alu_result == '0) & ~bus.FlushE;
    assign bus.PCTargetE = bus.PCE + bus.ImmExtE;

    // EX/MEM register; a flush turns the slot into a bubble by dropping its write enables
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.RegWriteM  <= 1'b0;
            bus.MemWriteM  <= 1'b0;
            bus.ResultSrcM <= 1'b0;
            bus.RDM        <= '0;
            bus.ALUResultM <= '0;
            bus.WriteDataM <= '0;
            bus.PCPlus4M   <= '0;
        end else begin
            bus.RegWriteM  <= bus.RegWriteE & ~bus.FlushE;
            bus.MemWriteM  <= bus.MemWriteE & ~bus.FlushE;
            bus.ResultSrcM <= bus.ResultSrcE;
            bus.RDM        <= bus.RDE;
            bus.ALUResultM <= alu_result;
            bus.WriteDataM <= fwd_b;
            bus.PCPlus4M   <= bus.PCPlus4E;
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed self-checking bench for execute_stage
module tb_execute_stage;
    logic clk = 1'b0;
    logic rst;
    int   compared = 0;
    int   mismatched = 0;

    execute_stage_if bus ();
    execute_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.RegWriteE   = 1'b0;
        bus.ALUSrcE     = 1'b0;
        bus.MemWriteE   = 1'b0;
        bus.ResultSrcE  = 1'b0;
        bus.BranchE     = 1'b0;
        bus.ALUControlE = 3'b000;
        bus.RD1E        = '0;
        bus.RD2E        = '0;
        bus.ImmExtE     = '0;
        bus.PCE         = '0;
        bus.PCPlus4E    = '0;
        bus.RDE         = '0;
        bus.ForwardAE   = 2'b00;
        bus.ForwardBE   = 2'b00;
        bus.ResultW     = '0;
        bus.FlushE      = 1'b0;
    endtask

    task automatic test_reset;
        logic [168:0] m_all;
        rst = 1'b1;
        bus.RegWriteE   = 1'b1;
        bus.ALUSrcE     = $urandom_range(1);
        bus.MemWriteE   = 1'b1;
        bus.ResultSrcE  = 1'b1;
        bus.BranchE     = $urandom_range(1);
        bus.ALUControlE = 3'($urandom_range(7));
        bus.RD1E        = $urandom;
        bus.RD2E        = $urandom;
        bus.ImmExtE     = $urandom;
        bus.PCE         = $urandom;
        bus.PCPlus4E    = $urandom | 32'h1;
        bus.RDE         = 5'($urandom_range(31, 1));
        bus.ForwardAE   = 2'($urandom_range(3));
        bus.ForwardBE   = 2'($urandom_range(3));
        bus.ResultW     = $urandom;
        bus.FlushE      = 1'b0;
        step();
        step();
        m_all = {bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM, bus.RDM, bus.ALUResultM, bus.WriteDataM, bus.PCPlus4M};
        compared++;
        if (m_all !== '0) begin
            mismatched++;
            $display("FAIL reset_m_outputs got %h exp 0", m_all);
        end
        idle();
        rst = 1'b0;
        bus.RegWriteE = 1'b1;
        bus.RDE       = 5'd5;
        bus.RD1E      = 32'd7;
        bus.RD2E      = 32'd3;
        bus.PCPlus4E  = 32'h104;
        #1;
        compared++;
        if (bus.ALUResultM !== 32'd0) begin
            mismatched++;
            $display("FAIL release_no_early_capture got %h exp 0", bus.ALUResultM);
        end
        step();
        compared++;
        if ({bus.RegWriteM, bus.RDM, bus.ALUResultM, bus.PCPlus4M} !== {1'b1, 5'd5, 32'd10, 32'h104}) begin
            mismatched++;
            $display("FAIL release_first_capture got %b/%0d/%h/%h exp 1/5/0000000a/00000104",
                     bus.RegWriteM, bus.RDM, bus.ALUResultM, bus.PCPlus4M);
        end
    endtask

    task automatic test_alu_ops;
        logic [2:0]  ctrl [10] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b001, 3'b101, 3'b100, 3'b110, 3'b111};
        logic [31:0] a    [10] = '{7, 7, 7, 7, 32'hFFFFFFFF, 0, 1, 7, 7, 7};
        logic [31:0] b    [10] = '{3, 3, 3, 3, 1, 1, 32'hFFFFFFFF, 3, 3, 3};
        logic [31:0] e    [10] = '{10, 4, 3, 7, 1, 32'hFFFFFFFF, 0, 0, 0, 0};
        idle();
        for (int i = 0; i < 10; i++) begin
            bus.ALUControlE = ctrl[i];
            bus.RD1E        = a[i];
            bus.RD2E        = b[i];
            step();
            compared++;
            if (bus.ALUResultM !== e[i]) begin
                mismatched++;
                $display("FAIL alu_op%0d ctrl=%b got %h exp %h", i, ctrl[i], bus.ALUResultM, e[i]);
            end
            compared++;
            if (bus.WriteDataM !== b[i]) begin
                mismatched++;
                $display("FAIL alu_writedata%0d got %h exp %h", i, bus.WriteDataM, b[i]);
            end
        end
    endtask

    task automatic test_imm_store;
        idle();
        bus.ALUSrcE   = 1'b1;
        bus.ImmExtE   = 32'hFFFFFFFC;
        bus.RD1E      = 32'h100;
        bus.RD2E      = 32'hDEADBEEF;
        bus.MemWriteE = 1'b1;
        bus.ResultSrcE = 1'b1;
        step();
        compared++;
        if ({bus.ALUResultM, bus.WriteDataM, bus.MemWriteM, bus.ResultSrcM} !== {32'hFC, 32'hDEADBEEF, 1'b1, 1'b1}) begin
            mismatched++;
            $display("FAIL imm_store got %h/%h/%b/%b exp 000000fc/deadbeef/1/1",
                     bus.ALUResultM, bus.WriteDataM, bus.MemWriteM, bus.ResultSrcM);
        end
    endtask

    task automatic test_forwarding;
        idle();
        bus.RD1E = 32'd5;
        bus.RD2E = 32'd6;
        step();
        compared++;
        if (bus.ALUResultM !== 32'd11) begin
            mismatched++;
            $display("FAIL fwd_setup got %h exp 0000000b", bus.ALUResultM);
        end
        bus.ForwardAE   = 2'b10;
        bus.ForwardBE   = 2'b01;
        bus.ResultW     = 32'd20;
        bus.RD1E        = 32'd100;
        bus.RD2E        = 32'd200;
        bus.ALUControlE = 3'b001;
        step();
        compared++;
        if ({bus.ALUResultM, bus.WriteDataM} !== {32'hFFFFFFF7, 32'd20}) begin
            mismatched++;
            $display("FAIL fwd_mem_wb got %h/%h exp fffffff7/00000014", bus.ALUResultM, bus.WriteDataM);
        end
        bus.ForwardBE   = 2'b00;
        bus.RD2E        = 32'd1;
        bus.ALUControlE = 3'b000;
        step();
        compared++;
        if (bus.ALUResultM !== 32'hFFFFFFF8) begin
            mismatched++;
            $display("FAIL fwd_back_to_back got %h exp fffffff8", bus.ALUResultM);
        end
        bus.ForwardBE = 2'b10;
        bus.RD2E      = 32'd0;
        step();
        compared++;
        if ({bus.ALUResultM, bus.WriteDataM} !== {32'hFFFFFFF0, 32'hFFFFFFF8}) begin
            mismatched++;
            $display("FAIL fwd_b_mem got %h/%h exp fffffff0/fffffff8", bus.ALUResultM, bus.WriteDataM);
        end
        bus.ForwardAE = 2'b11;
        bus.ForwardBE = 2'b11;
        bus.RD1E      = 32'd4;
        bus.RD2E      = 32'd2;
        step();
        compared++;
        if ({bus.ALUResultM, bus.WriteDataM} !== {32'd6, 32'd2}) begin
            mismatched++;
            $display("FAIL fwd_code11 got %h/%h exp 00000006/00000002", bus.ALUResultM, bus.WriteDataM);
        end
        bus.ForwardAE = 2'b00;
        bus.ForwardBE = 2'b01;
        bus.ALUSrcE   = 1'b1;
        bus.RD1E      = 32'd1;
        bus.ImmExtE   = 32'd2;
        step();
        compared++;
        if ({bus.ALUResultM, bus.WriteDataM} !== {32'd3, 32'd20}) begin
            mismatched++;
            $display("FAIL fwd_store_imm got %h/%h exp 00000003/00000014", bus.ALUResultM, bus.WriteDataM);
        end
    endtask

    task automatic test_branch;
        idle();
        bus.BranchE     = 1'b1;
        bus.ALUControlE = 3'b001;
        bus.RD1E        = 32'd9;
        bus.RD2E        = 32'd9;
        bus.PCE         = 32'h40;
        bus.ImmExtE     = 32'h10;
        #1;
        compared++;
        if ({bus.PCSrcE, bus.PCTargetE} !== {1'b1, 32'h50}) begin
            mismatched++;
            $display("FAIL branch_taken got %b/%h exp 1/00000050", bus.PCSrcE, bus.PCTargetE);
        end
        bus.RD2E = 32'd8;
        #1;
        compared++;
        if (bus.PCSrcE !== 1'b0) begin
            mismatched++;
            $display("FAIL branch_not_taken got %b exp 0", bus.PCSrcE);
        end
        bus.RD2E    = 32'd9;
        bus.BranchE = 1'b0;
        #1;
        compared++;
        if (bus.PCSrcE !== 1'b0) begin
            mismatched++;
            $display("FAIL branch_no_beq got %b exp 0", bus.PCSrcE);
        end
        bus.PCE     = 32'hFFFFFFF0;
        bus.ImmExtE = 32'h20;
        #1;
        compared++;
        if (bus.PCTargetE !== 32'h10) begin
            mismatched++;
            $display("FAIL target_wrap got %h exp 00000010", bus.PCTargetE);
        end
    endtask

    task automatic test_flush;
        idle();
        bus.BranchE     = 1'b1;
        bus.ALUControlE = 3'b001;
        bus.RD1E        = 32'd9;
        bus.RD2E        = 32'd9;
        bus.PCE         = 32'h40;
        bus.ImmExtE     = 32'h10;
        bus.RegWriteE   = 1'b1;
        bus.MemWriteE   = 1'b1;
        bus.RDE         = 5'd7;
        bus.PCPlus4E    = 32'h44;
        bus.FlushE      = 1'b1;
        #1;
        compared++;
        if (bus.PCSrcE !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_pcsrc got %b exp 0", bus.PCSrcE);
        end
        step();
        compared++;
        if ({bus.RegWriteM, bus.MemWriteM, bus.RDM, bus.PCPlus4M, bus.WriteDataM} !== {1'b0, 1'b0, 5'd7, 32'h44, 32'd9}) begin
            mismatched++;
            $display("FAIL flush_bubble got %b/%b/%0d/%h/%h exp 0/0/7/00000044/00000009",
                     bus.RegWriteM, bus.MemWriteM, bus.RDM, bus.PCPlus4M, bus.WriteDataM);
        end
        bus.ALUControlE = 3'b000;
        bus.ResultSrcE  = 1'b1;
        rst = 1'b1;
        step();
        compared++;
        if ({bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM, bus.RDM, bus.ALUResultM, bus.WriteDataM, bus.PCPlus4M} !== '0) begin
            mismatched++;
            $display("FAIL rst_and_flush got %b/%b/%b/%0d/%h/%h/%h exp all 0", bus.RegWriteM, bus.MemWriteM,
                     bus.ResultSrcM, bus.RDM, bus.ALUResultM, bus.WriteDataM, bus.PCPlus4M);
        end
        bus.ALUControlE = 3'b001;
        bus.FlushE      = 1'b0;
        #1;
        compared++;
        if (bus.PCSrcE !== 1'b1) begin
            mismatched++;
            $display("FAIL pcsrc_during_rst got %b exp 1", bus.PCSrcE);
        end
        rst = 1'b0;
        idle();
        bus.RegWriteE = 1'b1;
        bus.RDE       = 5'd0;
        bus.RD1E      = 32'd1;
        step();
        compared++;
        if ({bus.RegWriteM, bus.RDM, bus.ALUResultM} !== {1'b1, 5'd0, 32'd1}) begin
            mismatched++;
            $display("FAIL x0_passthrough got %b/%0d/%h exp 1/0/00000001", bus.RegWriteM, bus.RDM, bus.ALUResultM);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #2;
        test_reset();
        test_alu_ops();
        test_imm_store();
        test_forwarding();
        test_branch();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
